// File: rtl/seq_detector_pkg.sv
// ============================================================================
//  Module      : seq_detector_pkg
//  Description : Shared constants and helper functions for the parametrised
//                serial sequence detector (mode encodings, state-width
//                function, KMP prefix/suffix compare helper).
//  Optional    : none in this file (SEQ_DETECTOR_MEALY_EN is used by the top)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_detector_pkg;

   // Detection mode encodings on input M
   localparam logic MODE_NONOVL = 1'b0;
   localparam logic MODE_OVL    = 1'b1;

   // Widest supported pattern; the compare helper works on vectors this wide
   localparam int MAX_PAT_W = 16;

   // State register width: states 0..pat_w inclusive
   function automatic int seq_qw(input int pat_w);
      return $clog2(pat_w + 1);
   endfunction

   // Prefix-compare helper.
   // p holds the pattern with p[0] = first bit received.
   // S is the string p[0..q_len-1] followed by x. Returns 1 when the last k
   // bits of S equal the first k pattern bits (k = 0 always matches).
   function automatic logic kmp_suffix_ok(input logic [MAX_PAT_W-1:0] p,
                                          input logic [4:0]           q_len,
                                          input logic [4:0]           k,
                                          input logic                 x);
      int         qi;
      int         ki;
      logic       ok;
      logic [3:0] ia;
      logic [3:0] ib;
      qi = int'(q_len);
      ki = int'(k);
      ok = 1'b1;
      ia = '0;
      ib = '0;
      if (ki == 0) begin
         return 1'b1;
      end
      if (ki > qi + 1) begin
         return 1'b0;
      end
      // All but the last compared bit come from the remembered prefix
      for (int j = 0; j < MAX_PAT_W - 1; j++) begin
         if (j < ki - 1) begin
            ia = 4'(qi + 1 - ki + j);
            ib = 4'(j);
            ok = ok & (p[ia] == p[ib]);
         end
      end
      ib = 4'(ki - 1);
      ok = ok & (x == p[ib]);
      return ok;
   endfunction

endpackage : seq_detector_pkg

`default_nettype wire

// File: rtl/seq_detector_next_state.sv
// ============================================================================
//  Module      : seq_detector_next_state
//  Description : Purely combinational next-state function of the sequence
//                detector. Performs the KMP fallback search, unrolled over
//                every candidate prefix length k = 1..PAT_W, and picks the
//                longest prefix that is also a suffix of the accepted string.
//  Ports       : q_i       current state (matched prefix length)
//                x_i       incoming serial bit
//                m_i       mode (0 = non-overlapping, 1 = overlapping)
//                pattern_i active pattern, MSB is first bit received
//                nq_o      next state
//                match_o   next state is the MATCH state
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_detector_next_state
   import seq_detector_pkg::*;
#(
   parameter int PAT_W = 5,
   parameter int QW    = 3
) (
   input  logic [QW-1:0]    q_i,
   input  logic             x_i,
   input  logic             m_i,
   input  logic [PAT_W-1:0] pattern_i,
   output logic [QW-1:0]    nq_o,
   output logic             match_o
);

   localparam logic [QW-1:0] ST_IDLE  = '0;
   localparam logic [QW-1:0] ST_MATCH = QW'(PAT_W);

   logic [MAX_PAT_W-1:0] pv_w;      // pattern re-ordered: index 0 = first bit
   logic [4:0]           q_eff_w;   // length of remembered prefix in S
   logic [PAT_W-1:0]     hit_w;     // hit_w[k-1]: prefix of length k fits
   logic [QW-1:0]        cand_w [0:PAT_W];

   for (genvar i = 0; i < PAT_W; i++) begin : g_rev
      assign pv_w[i] = pattern_i[PAT_W-1-i];
   end

   if (PAT_W < MAX_PAT_W) begin : g_pad
      assign pv_w[MAX_PAT_W-1:PAT_W] = '0;
   end

   // Leaving MATCH in non-overlapping mode restarts from X alone; an
   // out-of-range state (never reached normally) is treated as empty too.
   always_comb begin
      q_eff_w = 5'(q_i);
      if ((q_i > ST_MATCH) || ((q_i == ST_MATCH) && (m_i == MODE_NONOVL))) begin
         q_eff_w = '0;
      end
   end

   // Longest-fit selection: each stage overrides the shorter candidate
   assign cand_w[0] = ST_IDLE;

   for (genvar k = 1; k <= PAT_W; k++) begin : g_k
      assign hit_w[k-1] = kmp_suffix_ok(pv_w, q_eff_w, 5'(k), x_i);
      assign cand_w[k]  = hit_w[k-1] ? QW'(k) : cand_w[k-1];
   end

   assign nq_o    = cand_w[PAT_W];
   assign match_o = hit_w[PAT_W-1];

endmodule : seq_detector_next_state

`default_nettype wire

// File: rtl/seq_detector_param.sv
// ============================================================================
//  Module      : seq_detector_param
//  Description : Parametrised serial sequence detector. Detects a
//                programmable PAT_W-bit pattern on X with overlapping or
//                non-overlapping detection, registered Moore flag, optional
//                Mealy flag and a saturating match counter.
//  Optional    : `define SEQ_DETECTOR_MEALY_EN to drive Z_mealy; otherwise
//                Z_mealy is tied to 0.
//  Ports       : clk, reset (sync, active-high)
//                en        bit-valid for X
//                X         serial data bit
//                M         0 = non-overlapping, 1 = overlapping
//                pat_load  load pat_in into the pattern register
//                pat_in    new pattern, MSB first received
//                cnt_clr   clear match_cnt
//                Z         Moore match flag (registered)
//                Z_mealy   Mealy match flag (combinational)
//                Q         current state (matched prefix length)
//                match_cnt number of matches, saturating
//                cnt_sat   match_cnt is all-ones
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_detector_param
   import seq_detector_pkg::*;
#(
   parameter int               PAT_W   = 5,
   parameter logic [PAT_W-1:0] PATTERN = 5'b10011,
   parameter int               CNT_W   = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     en,
   input  logic                     X,
   input  logic                     M,
   input  logic                     pat_load,
   input  logic [PAT_W-1:0]         pat_in,
   input  logic                     cnt_clr,
   output logic                     Z,
   output logic                     Z_mealy,
   output logic [seq_qw(PAT_W)-1:0] Q,
   output logic [CNT_W-1:0]         match_cnt,
   output logic                     cnt_sat
);

   localparam int             QW       = seq_qw(PAT_W);
   localparam logic [QW-1:0]  ST_IDLE  = '0;
   localparam logic [QW-1:0]  ST_MATCH = QW'(PAT_W);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [PAT_W-1:0] pattern_q, pattern_d;
   logic [QW-1:0]    state_q,   state_d;
   logic             z_q,       z_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;

   logic [QW-1:0]    nq_w;
   logic             nmatch_w;
   logic             accept_w;

   // A bit is accepted only when valid and not overridden by a pattern load
   assign accept_w = en & ~pat_load;

   seq_detector_next_state #(
      .PAT_W (PAT_W),
      .QW    (QW)
   ) u_next_state (
      .q_i       (state_q),
      .x_i       (X),
      .m_i       (M),
      .pattern_i (pattern_q),
      .nq_o      (nq_w),
      .match_o   (nmatch_w)
   );

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk) begin
      if (reset) begin
         pattern_q <= PATTERN;
         state_q   <= ST_IDLE;
         z_q       <= 1'b0;
         cnt_q     <= '0;
      end else begin
         pattern_q <= pattern_d;
         state_q   <= state_d;
         z_q       <= z_d;
         cnt_q     <= cnt_d;
      end
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      pattern_d = pattern_q;
      state_d   = state_q;
      cnt_d     = cnt_q;

      if (pat_load) begin
         pattern_d = pat_in;
         state_d   = ST_IDLE;
      end else if (en) begin
         state_d = nq_w;
      end

      if (cnt_clr) begin
         cnt_d = '0;
      end else if (accept_w && nmatch_w && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_ONE;
      end

      // Z tracks the registered state exactly: high whenever Q is MATCH
      z_d = (state_d == ST_MATCH);
   end

   // --------------------------------------------------------------- output
   always_comb begin
`ifdef SEQ_DETECTOR_MEALY_EN
      Z_mealy = accept_w & nmatch_w;
`else
      Z_mealy = 1'b0;
`endif
      cnt_sat = (cnt_q == CNT_MAX);
   end

   assign Q         = state_q;
   assign Z         = z_q;
   assign match_cnt = cnt_q;

endmodule : seq_detector_param

`default_nettype wire

// File: tb/tb_seq_detector_param.sv
// ============================================================================
//  Module      : tb_seq_detector_param
//  Description : Directed self-checking bench for seq_detector_param.
//                Three instances share the control inputs: the default
//                configuration, a 2-bit counter variant and a 4-bit pattern
//                variant.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_detector_param;

`ifdef SEQ_DETECTOR_MEALY_EN
   localparam logic MEALY_ON = 1'b1;
`else
   localparam logic MEALY_ON = 1'b0;
`endif

   logic       clk;
   logic       reset;
   logic       en;
   logic       X;
   logic       M;
   logic       pat_load;
   logic [4:0] pat_in5;
   logic [3:0] pat_in4;
   logic       cnt_clr;

   logic       z_a, zm_a, sat_a;
   logic [2:0] q_a;
   logic [7:0] cnt_a;

   logic       z_b, zm_b, sat_b;
   logic [2:0] q_b;
   logic [1:0] cnt_b;

   logic       z_c, zm_c, sat_c;
   logic [2:0] q_c;
   logic [7:0] cnt_c;

   int n_checks;
   int n_errors;

   seq_detector_param dut (
      .clk(clk), .reset(reset), .en(en), .X(X), .M(M),
      .pat_load(pat_load), .pat_in(pat_in5), .cnt_clr(cnt_clr),
      .Z(z_a), .Z_mealy(zm_a), .Q(q_a), .match_cnt(cnt_a), .cnt_sat(sat_a)
   );

   seq_detector_param #(.CNT_W(2)) dut_c2 (
      .clk(clk), .reset(reset), .en(en), .X(X), .M(M),
      .pat_load(pat_load), .pat_in(pat_in5), .cnt_clr(cnt_clr),
      .Z(z_b), .Z_mealy(zm_b), .Q(q_b), .match_cnt(cnt_b), .cnt_sat(sat_b)
   );

   seq_detector_param #(.PAT_W(4), .PATTERN(4'b0000)) dut_p4 (
      .clk(clk), .reset(reset), .en(en), .X(X), .M(M),
      .pat_load(pat_load), .pat_in(pat_in4), .cnt_clr(cnt_clr),
      .Z(z_c), .Z_mealy(zm_c), .Q(q_c), .match_cnt(cnt_c), .cnt_sat(sat_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance past the next rising edge; outputs are sampled 1 time unit later
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one input bit; combinational outputs settle before the next edge
   task automatic apply(input logic e, input logic x);
      en = e;
      X  = x;
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic load5(input logic [4:0] p);
      pat_load = 1'b1;
      pat_in5  = p;
      en       = 1'b0;
      tick();
      pat_load = 1'b0;
   endtask

   task automatic load4(input logic [3:0] p);
      pat_load = 1'b1;
      pat_in4  = p;
      en       = 1'b0;
      tick();
      pat_load = 1'b0;
   endtask

   initial begin
      logic [4:0] seq5;
      logic [6:0] seq7;
      n_checks = 0;
      n_errors = 0;
      reset    = 1'b1;
      en       = 1'b0;
      X        = 1'b0;
      M        = 1'b1;
      pat_load = 1'b0;
      pat_in5  = '0;
      pat_in4  = '0;
      cnt_clr  = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      // ---------------- reset state
      check("rst_Q",     32'(q_a),   0);
      check("rst_Z",     32'(z_a),   0);
      check("rst_cnt",   32'(cnt_a), 0);
      check("rst_sat",   32'(sat_a), 0);
      check("rst_mealy", 32'(zm_a),  0);

      // ---------------- default pattern 10011, overlapping
      seq5 = 5'b10011;
      for (int i = 0; i < 5; i++) begin
         apply(1'b1, seq5[4-i]);
         if (i == 3) check("t1_mealy_b4", 32'(zm_a), 0);
         if (i == 4) check("t1_mealy_b5", 32'(zm_a), 32'(MEALY_ON));
         if (i == 4) check("t1_Z_before", 32'(z_a), 0);
         tick();
         check("t1_Q", 32'(q_a), 32'(i + 1));
      end
      check("t1_Z",   32'(z_a),   1);
      check("t1_cnt", 32'(cnt_a), 1);
      apply(1'b0, 1'b0);
      tick();
      check("t1_Z_hold", 32'(z_a), 1);
      check("t1_Q_hold", 32'(q_a), 5);

      // ---------------- 4-bit pattern 1011, overlapping
      do_reset();
      load4(4'b1011);
      M    = 1'b1;
      seq7 = 7'b1011011;
      for (int i = 0; i < 7; i++) begin
         apply(1'b1, seq7[6-i]);
         tick();
         if (i == 3) check("t2o_Q_b4", 32'(q_c), 4);
         if (i == 4) check("t2o_Q_b5", 32'(q_c), 2);
      end
      check("t2o_cnt", 32'(cnt_c), 2);
      check("t2o_Z",   32'(z_c),   1);

      // ---------------- 4-bit pattern 1011, non-overlapping
      do_reset();
      load4(4'b1011);
      M = 1'b0;
      for (int i = 0; i < 7; i++) begin
         apply(1'b1, seq7[6-i]);
         tick();
      end
      check("t2n_cnt", 32'(cnt_c), 1);
      check("t2n_Q",   32'(q_c),   1);
      check("t2n_Z",   32'(z_c),   0);

      // ---------------- en gap holds state
      do_reset();
      M = 1'b1;
      for (int i = 0; i < 4; i++) begin
         apply(1'b1, seq5[4-i]);
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         apply(1'b0, 1'b0);
         tick();
         check("t3_Q_gap", 32'(q_a), 4);
         check("t3_Z_gap", 32'(z_a), 0);
      end
      apply(1'b1, 1'b1);
      tick();
      check("t3_Q", 32'(q_a), 5);
      check("t3_Z", 32'(z_a), 1);
      check("t3_cnt", 32'(cnt_a), 1);

      // ---------------- counter saturation and clear priority
      do_reset();
      load5(5'b11111);
      M = 1'b1;
      for (int i = 0; i < 9; i++) begin
         apply(1'b1, 1'b1);
         tick();
      end
      check("t4_cnt2",     32'(cnt_b), 3);
      check("t4_sat2",     32'(sat_b), 1);
      check("t4_cnt8",     32'(cnt_a), 5);
      check("t4_sat8",     32'(sat_a), 0);
      check("t4_Q2",       32'(q_b),   5);
      cnt_clr = 1'b1;
      apply(1'b1, 1'b1);
      tick();
      cnt_clr = 1'b0;
      check("t4_clr_cnt2", 32'(cnt_b), 0);
      check("t4_clr_sat2", 32'(sat_b), 0);
      check("t4_clr_cnt8", 32'(cnt_a), 0);
      check("t4_clr_Z",    32'(z_b),   1);

      // ---------------- pattern load mid-stream discards the bit
      do_reset();
      M = 1'b1;
      for (int i = 0; i < 3; i++) begin
         apply(1'b1, seq5[4-i]);
         tick();
      end
      check("t5_Q_pre", 32'(q_a), 3);
      pat_load = 1'b1;
      pat_in5  = 5'b11111;
      apply(1'b1, 1'b1);
      check("t5_mealy_ld", 32'(zm_a), 0);
      tick();
      pat_load = 1'b0;
      check("t5_Q_ld", 32'(q_a), 0);
      for (int i = 0; i < 4; i++) begin
         apply(1'b1, 1'b1);
         tick();
      end
      check("t5_Q4", 32'(q_a), 4);
      check("t5_Z4", 32'(z_a), 0);
      apply(1'b1, 1'b1);
      tick();
      check("t5_Q5",  32'(q_a),   5);
      check("t5_Z5",  32'(z_a),   1);
      check("t5_cnt", 32'(cnt_a), 1);

      // ---------------- reset mid-operation restores default pattern
      apply(1'b1, 1'b0);
      tick();
      check("t6_Q0", 32'(q_a), 0);
      for (int i = 0; i < 4; i++) begin
         apply(1'b1, 1'b1);
         tick();
      end
      check("t6_Q4",   32'(q_a),   4);
      check("t6_cnt1", 32'(cnt_a), 1);
      reset = 1'b1;
      apply(1'b1, 1'b1);
      tick();
      reset = 1'b0;
      check("t6_rst_Q",   32'(q_a),   0);
      check("t6_rst_Z",   32'(z_a),   0);
      check("t6_rst_cnt", 32'(cnt_a), 0);
      // With 10011 restored, "11" leaves only a 1-bit prefix matched
      apply(1'b1, 1'b1);
      tick();
      apply(1'b1, 1'b1);
      tick();
      check("t6_Q_11", 32'(q_a), 1);
      apply(1'b1, 1'b0); tick();
      apply(1'b1, 1'b0); tick();
      apply(1'b1, 1'b1); tick();
      apply(1'b1, 1'b1); tick();
      check("t6_Q_match", 32'(q_a), 5);
      check("t6_Z_match", 32'(z_a), 1);

      apply(1'b0, 1'b0);
      tick();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_seq_detector_param

`default_nettype wire

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised successor to the team's fixed 5-bit Moore sequence detector.
- Detects a programmable serial bit pattern of PAT_W bits on input X and selects overlapping or non-overlapping detection with M.
- Provides a registered Moore output, an optional Mealy output and a saturating match counter.
- Sits on the serial input path of the RISC datapath test harness, where it replaces hard-wired detectors.

Parameters:
- PAT_W, 5, pattern length in bits; legal range 2..16.
- PATTERN, 5'b10011, pattern loaded at reset; MSB is the first bit received.
- CNT_W, 8, match counter width; minimum 1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  bit-valid; X is sampled only on cycles where en=1.
- X  in  1  serial data bit.
- M  in  1  detection mode: 0 = non-overlapping, 1 = overlapping.
- pat_load  in  1  load pat_in into the pattern register.
- pat_in  in  PAT_W  new pattern; MSB is the first bit received.
- cnt_clr  in  1  clear match_cnt.
- Z  out  1  Moore match flag, registered.
- Z_mealy  out  1  Mealy match flag, combinational.
- Q  out  QW  current state; QW = clog2(PAT_W+1).
- match_cnt  out  CNT_W  number of matches detected.
- cnt_sat  out  1  high while match_cnt is all-ones.

Behaviour:
- Reset (synchronous, active-high) loads these values:
  - pattern register = PATTERN
  - Q = 0, Z = 0, match_cnt = 0, cnt_sat = 0
  - Z_mealy = 0, because Q = 0 and en is ignored during reset.
- State meaning: Q = k (0..PAT_W) means the last k accepted bits equal the first k bits of the pattern, with k maximal. Q = PAT_W is the MATCH state.
- Next state (nq) on a cycle with en=1, pat_load=0:
  - Let S = the first Q pattern bits followed by X.
  - If Q == PAT_W and M == 0: S = X alone, so the detector restarts after a match.
  - nq = the largest k ≤ min(len(S), PAT_W) such that the last k bits of S equal the first k pattern bits. This is a KMP fallback; there is no blind return to 0.
- en = 0: Q holds; no count change.
- Moore output: Z = (Q == PAT_W), registered from Q.
  - Z asserts on the cycle after the final pattern bit is accepted.
  - Z stays high for 1 cycle unless the next accepted bit re-enters MATCH; it holds while en = 0.
- Mealy output: Z_mealy = en & ~pat_load & (nq == PAT_W). It is high in the same cycle as the final bit, 1 cycle ahead of Z.
- M is sampled on every accepted bit. A change of M affects only the transition out of MATCH.
- pat_load = 1:
  - The pattern register takes pat_in, Q goes to 0 and the bit on that cycle is discarded (load wins over en).
  - match_cnt is unaffected.
- match_cnt increments by 1 on every cycle with en=1, pat_load=0 and nq == PAT_W.
  - It saturates at 2^CNT_W-1 and never wraps.
  - cnt_sat = (match_cnt == all-ones).
- cnt_clr = 1 sets match_cnt to 0 next cycle. When cnt_clr and an increment coincide, clear wins and the result is 0.
- Reset mid-operation aborts any partial match. A pattern loaded earlier via pat_load is lost and the register returns to PATTERN.

Optional Feature:
- Macro: SEQ_DETECTOR_MEALY_EN.
- Defined: Z_mealy is driven as specified above.
- Undefined: the Z_mealy port remains, tied to 0, and its next-state compare logic is not built.
- Z, Q and match_cnt are identical in both builds.

Decomposition:
- Package seq_detector_pkg holds:
  - constants MODE_NONOVL = 1'b0 and MODE_OVL = 1'b1
  - a function for state width QW from PAT_W
  - a prefix-compare helper function
- Sub-module seq_detector_next_state: purely combinational.
  - Inputs: Q, X, M, pattern.
  - Outputs: nq and a match flag.
  - It contains the KMP fallback search, unrolled over k.
- The top level holds the state, pattern and counter registers and the output logic.

Test Plan:
- Default pattern, M=1, en=1, stream 1,0,0,1,1 -> Q = 1,2,3,4,5; Z_mealy high with the 5th bit; Z high the next cycle; match_cnt = 1.
- Load 1011, stream 1,0,1,1,0,1,1:
  - M=1 -> matches after bits 4 and 7, match_cnt = 2.
  - M=0 -> match only after bit 4, match_cnt = 1, final Q = 1.
- Default pattern, stream 1,0,0,1 then en=0 for 3 cycles, then X=1 with en=1 -> Q holds at 4 during the gap; Z asserts after the final bit.
- CNT_W=2, 5 back-to-back matches -> match_cnt = 3 with cnt_sat = 1; cnt_clr together with a match -> match_cnt = 0.
- Stream 1,0,0, then pat_load with pat_in=5'b11111 while en=1 -> Q = 0, bit discarded, new pattern active; then five 1s -> match.
- Reach Q=4, then assert reset for 1 cycle -> Q = 0, Z = 0, match_cnt = 0, pattern back to 10011.
